// File: rtl/accelerator_pkg.sv
// accelerator_pkg: shared types and constants for the vector store path
package accelerator_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} vst_state_t;
  localparam int VLEN_BYTES      = 16;
  localparam int MAX_GROUP_BYTES = 64;
  // Bytes moved by one store: vl elements of 2^vsew bytes, capped at one 4-register group
  function automatic logic [6:0] total_bytes(input logic [4:0] vl, input logic [1:0] sew);
    logic [6:0] n;
    n = (sew == 2'b11) ? 7'd0 : (7'(vl) << sew);
    return (n > 7'(MAX_GROUP_BYTES)) ? 7'(MAX_GROUP_BYTES) : n;
  endfunction
endpackage

// File: rtl/vector_store_unit_if.sv
// vector_store_unit_if: OBI write-master bus between the store unit and memory
interface vector_store_unit_if;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i
  );
  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i
  );
endinterface

// File: rtl/store_lane_aligner.sv
// store_lane_aligner: steers cnt consecutive register bytes onto word lanes starting at i_lane
module store_lane_aligner (
  input  logic [127:0] i_rdata,
  input  logic [3:0]   i_b,
  input  logic [1:0]   i_lane,
  input  logic [2:0]   i_cnt,
  output logic [31:0]  o_wdata,
  output logic [3:0]   o_be
);
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic       w_en;
    logic [3:0] w_idx;
    assign w_en  = (3'(l) >= {1'b0, i_lane}) && (3'(l) < {1'b0, i_lane} + i_cnt);
    assign w_idx = i_b + 4'(l) - {2'b00, i_lane};
    assign o_be[l] = w_en;
    assign o_wdata[8*l +: 8] = w_en ? i_rdata[{w_idx, 3'b000} +: 8] : 8'h00;
  end
endmodule

// File: rtl/vector_store_unit.sv
// vector_store_unit: packs vector register bytes into aligned OBI word writes
module vector_store_unit
  import accelerator_pkg::*;
(
  input  logic         clk,
  input  logic         n_reset,
  input  logic [4:0]   vl_i,
  input  logic [1:0]   vsew_i,
  input  logic         vst_en_i,
  input  logic         vst_strided_i,
  output logic         vst_ready_o,
  output logic         vst_done_o,
  input  logic [31:0]  op0_data_i,
  input  logic [31:0]  op1_data_i,
  input  logic [4:0]   vr_addr_i,
  output logic [4:0]   vs_raddr_o,
  input  logic [127:0] vs_rdata_i,
  vector_store_unit_if.master obi
);
  vst_state_t  r_state, w_next;
  logic [4:0]  r_vl, r_vr;
  logic [1:0]  r_sew;
  logic        r_strided;
  logic [31:0] r_stride, r_addr;
  logic [6:0]  r_b;
  logic [6:0]  w_total, w_rem, w_b_next, w_start_b;
  logic [2:0]  w_esz, w_lim_word, w_c1, w_c2, w_cnt;
  logic [4:0]  w_lim_reg;
  logic [31:0] w_step, w_wdata;
  logic [3:0]  w_be;
  logic        w_last, w_noop, w_req;
  // Transaction sizing: unit stride never crosses a word or register boundary
  always_comb begin
    w_total    = total_bytes(r_vl, r_sew);
    w_esz      = 3'(1) << r_sew;
    w_rem      = w_total - r_b;
    w_lim_word = 3'd4 - {1'b0, r_addr[1:0]};
    w_lim_reg  = 5'd16 - {1'b0, r_b[3:0]};
    w_c1       = (w_rem < 7'(w_lim_word)) ? w_rem[2:0] : w_lim_word;
    w_c2       = (7'(w_lim_reg) < 7'(w_c1)) ? w_lim_reg[2:0] : w_c1;
    w_cnt      = r_strided ? w_esz : w_c2;
    w_step     = r_strided ? r_stride : 32'(w_cnt);
    w_b_next   = r_b + 7'(w_cnt);
    w_last     = w_b_next >= w_total;
    w_noop     = (vl_i == 5'd0) || (vsew_i == 2'b11);
    w_start_b  = (vst_strided_i && op1_data_i == 32'd0) ? total_bytes(vl_i, vsew_i) - 7'(3'(1) << vsew_i) : 7'd0;
  end
  // Next-state logic; stride 0 starts at the last element so only it is written
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = vst_en_i ? (w_noop ? DONE : REQ) : IDLE;
      REQ:     w_next = obi.data_gnt_i ? RESP : REQ;
      RESP:    w_next = obi.data_rvalid_i ? (w_last ? DONE : REQ) : RESP;
      default: w_next = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Operand latch at start; address and byte index advance on each write response
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_vl      <= '0;
      r_sew     <= '0;
      r_strided <= 1'b0;
      r_stride  <= '0;
      r_vr      <= '0;
      r_addr    <= '0;
      r_b       <= '0;
    end else if (r_state == IDLE && vst_en_i) begin
      r_vl      <= vl_i;
      r_sew     <= vsew_i;
      r_strided <= vst_strided_i;
      r_stride  <= op1_data_i;
      r_vr      <= vr_addr_i;
      r_addr    <= op0_data_i;
      r_b       <= w_start_b;
    end else if (r_state == RESP && obi.data_rvalid_i) begin
      r_addr    <= r_addr + w_step;
      r_b       <= w_b_next;
    end
  end
  store_lane_aligner u_align (
    .i_rdata (vs_rdata_i),
    .i_b     (r_b[3:0]),
    .i_lane  (r_addr[1:0]),
    .i_cnt   (w_cnt),
    .o_wdata (w_wdata),
    .o_be    (w_be)
  );
  assign w_req            = r_state == REQ;
  assign obi.data_req_o   = w_req;
  assign obi.data_we_o    = w_req;
  assign obi.data_addr_o  = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign obi.data_be_o    = w_req ? w_be : 4'd0;
  assign obi.data_wdata_o = w_req ? w_wdata : 32'd0;
  assign vs_raddr_o       = r_vr + {3'b000, r_b[5:4]};
  assign vst_ready_o      = r_state == IDLE;
  assign vst_done_o       = r_state == DONE;
endmodule

// File: tb/tb_vector_store_unit.sv
// tb_vector_store_unit: scoreboard bench with an OBI slave and a register-file model
module tb_vector_store_unit;
  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic [4:0]   vl_i = '0;
  logic [1:0]   vsew_i = '0;
  logic         vst_en_i = 1'b0;
  logic         vst_strided_i = 1'b0;
  logic         vst_ready_o, vst_done_o;
  logic [31:0]  op0_data_i = '0;
  logic [31:0]  op1_data_i = '0;
  logic [4:0]   vr_addr_i = '0;
  logic [4:0]   vs_raddr_o;
  logic [127:0] vs_rdata_i;
  logic [127:0] regs [32];

  typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic [4:0] raddr;} txn_t;
  typedef struct {logic [4:0] vl; logic [1:0] sew; logic str; logic [31:0] base; logic [31:0] stride; logic [4:0] vr; int gw; int rw; int n;} vec_t;

  txn_t q[$];
  int tests = 0, fails = 0, cyc = 0, gw = 0, rw = 0, last_rv = 0, grants = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vector_store_unit_if bus();
  assign vs_rdata_i = regs[vs_raddr_o];

  vector_store_unit dut (
    .clk(clk), .n_reset(n_reset), .vl_i(vl_i), .vsew_i(vsew_i), .vst_en_i(vst_en_i),
    .vst_strided_i(vst_strided_i), .vst_ready_o(vst_ready_o), .vst_done_o(vst_done_o),
    .op0_data_i(op0_data_i), .op1_data_i(op1_data_i), .vr_addr_i(vr_addr_i),
    .vs_raddr_o(vs_raddr_o), .vs_rdata_i(vs_rdata_i), .obi(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void push_txn(input logic [31:0] a, input int b, input int cnt, input logic [4:0] vr);
    txn_t t;
    int lane, sb;
    t.addr = {a[31:2], 2'b00};
    t.be = '0;
    t.wdata = '0;
    t.raddr = 5'(int'(vr) + b / 16);
    for (int i = 0; i < cnt; i++) begin
      lane = int'(a[1:0]) + i;
      sb = b + i;
      t.be[lane] = 1'b1;
      t.wdata[8*lane +: 8] = regs[5'(int'(vr) + sb / 16)][8*(sb % 16) +: 8];
    end
    q.push_back(t);
  endfunction

  function automatic void model(input logic [4:0] vl, input logic [1:0] sew, input logic str,
                                input logic [31:0] base, input logic [31:0] stride, input logic [4:0] vr);
    int esz, total, ne, cnt, b;
    logic [31:0] a;
    if (vl == 0 || sew == 2'b11) return;
    esz = 1 << sew;
    total = int'(vl) * esz;
    if (total > 64) total = 64;
    if (str) begin
      ne = total / esz;
      for (int e = (stride == 0) ? ne - 1 : 0; e < ne; e++) push_txn(base + 32'(e) * stride, e * esz, esz, vr);
    end else begin
      a = base;
      b = 0;
      while (b < total) begin
        cnt = 4 - int'(a[1:0]);
        if (total - b < cnt) cnt = total - b;
        if (16 - b % 16 < cnt) cnt = 16 - b % 16;
        push_txn(a, b, cnt, vr);
        a = a + 32'(cnt);
        b = b + cnt;
      end
    end
  endfunction

  // OBI slave: programmable grant/response latency, stability and scoreboard checks
  initial begin : slave
    int wcnt, rcnt;
    bit pend;
    logic [31:0] s_addr, s_wd;
    logic [3:0] s_be;
    txn_t e;
    wcnt = 0; rcnt = 0; pend = 0;
    bus.data_gnt_i = 1'b0;
    bus.data_rvalid_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.data_gnt_i = 1'b0;
      bus.data_rvalid_i = 1'b0;
      if (!n_reset) begin
        pend = 0;
        wcnt = 0;
      end else if (pend) begin
        chk("no_req_while_outstanding", 32'(bus.data_req_o), 32'd0);
        if (rcnt >= rw) begin
          bus.data_rvalid_i = 1'b1;
          pend = 0;
          last_rv = cyc;
        end else rcnt++;
      end else if (bus.data_req_o) begin
        if (wcnt == 0) begin
          s_addr = bus.data_addr_o; s_be = bus.data_be_o; s_wd = bus.data_wdata_o;
        end else begin
          chk("stable_addr", bus.data_addr_o, s_addr);
          chk("stable_be", 32'(bus.data_be_o), 32'(s_be));
          chk("stable_wdata", bus.data_wdata_o, s_wd);
        end
        if (wcnt >= gw) begin
          bus.data_gnt_i = 1'b1;
          pend = 1; rcnt = 0; wcnt = 0;
          grants++;
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_txn: addr %h be %b with empty scoreboard", bus.data_addr_o, bus.data_be_o);
          end else begin
            e = q.pop_front();
            chk("addr", bus.data_addr_o, e.addr);
            chk("be", 32'(bus.data_be_o), 32'(e.be));
            chk("wdata", bus.data_wdata_o, e.wdata);
            chk("raddr", 32'(vs_raddr_o), 32'(e.raddr));
            chk("we", 32'(bus.data_we_o), 32'd1);
          end
        end else wcnt++;
      end
    end
  end

  task automatic run(input logic [4:0] a_vl, input logic [1:0] a_sew, input logic a_str, input logic [31:0] a_base,
                     input logic [31:0] a_stride, input logic [4:0] a_vr, input int g, input int r,
                     input bit use_model, input int n_exp);
    int g0;
    bit noop;
    gw = g; rw = r;
    noop = (a_vl == 0) || (a_sew == 2'b11);
    if (use_model) model(a_vl, a_sew, a_str, a_base, a_stride, a_vr);
    @(negedge clk);
    chk("ready_before_start", 32'(vst_ready_o), 32'd1);
    vl_i = a_vl; vsew_i = a_sew; vst_strided_i = a_str;
    op0_data_i = a_base; op1_data_i = a_stride; vr_addr_i = a_vr;
    vst_en_i = 1'b1;
    g0 = grants;
    @(negedge clk);
    vst_en_i = 1'b0;
    vl_i = 5'($urandom); vsew_i = 2'($urandom); vst_strided_i = 1'($urandom);
    op0_data_i = $urandom; op1_data_i = $urandom; vr_addr_i = 5'($urandom);
    if (noop) begin
      chk("noop_done_next_cycle", 32'(vst_done_o), 32'd1);
      chk("noop_no_req", 32'(bus.data_req_o), 32'd0);
    end else chk("first_req_latency", 32'(bus.data_req_o), 32'd1);
    for (int i = 0; i < 3000 && !vst_done_o; i++) @(negedge clk);
    if (!vst_done_o) begin
      tests++; fails++;
      $display("FAIL done_timeout: no vst_done_o within 3000 cycles");
      q.delete();
    end else begin
      if (!noop) chk("done_after_last_rvalid", 32'(cyc), 32'(last_rv + 1));
      chk("txn_count", 32'(grants - g0), 32'(n_exp));
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      @(negedge clk);
      chk("done_single_pulse", 32'(vst_done_o), 32'd0);
      chk("ready_after_done", 32'(vst_ready_o), 32'd1);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic [4:0] ra);
    txn_t t;
    t.addr = a; t.be = be; t.wdata = wd; t.raddr = ra;
    return t;
  endfunction

  initial begin : main
    vec_t tbl[9];
    int g0;
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < 16; k++) regs[r][8*k +: 8] = 8'(r * 16 + k - 64);
    regs[8][31:0] = 32'hAAAA_0001;
    regs[8][63:32] = 32'hBBBB_0002;
    regs[8][95:64] = 32'hCCCC_0003;
    tbl[0] = '{5'd3,  2'd2, 1'b1, 32'h2000, 32'd8,        5'd8,  0, 0, 3};
    tbl[1] = '{5'd4,  2'd1, 1'b1, 32'h1002, 32'd0,        5'd3,  1, 0, 1};
    tbl[2] = '{5'd4,  2'd1, 1'b1, 32'h1000, 32'd0,        5'd3,  0, 1, 1};
    tbl[3] = '{5'd10, 2'd1, 1'b0, 32'h0000, 32'd0,        5'd2,  3, 2, 5};
    tbl[4] = '{5'd5,  2'd2, 1'b1, 32'h0100, 32'hFFFFFFFC, 5'd6,  0, 0, 5};
    tbl[5] = '{5'd31, 2'd0, 1'b0, 32'h0005, 32'd0,        5'd7,  2, 1, 9};
    tbl[6] = '{5'd31, 2'd2, 1'b0, 32'h0000, 32'd0,        5'd30, 0, 0, 16};
    tbl[7] = '{5'd5,  2'd0, 1'b1, 32'h0001, 32'd3,        5'd9,  1, 1, 5};
    tbl[8] = '{5'd31, 2'd1, 1'b1, 32'h0202, 32'd0,        5'd11, 0, 0, 1};
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(vst_ready_o), 32'd1);
    chk("reset_done", 32'(vst_done_o), 32'd0);
    chk("reset_req", 32'(bus.data_req_o), 32'd0);
    chk("reset_we", 32'(bus.data_we_o), 32'd0);
    chk("reset_addr", bus.data_addr_o, 32'd0);
    chk("reset_be", 32'(bus.data_be_o), 32'd0);
    chk("reset_wdata", bus.data_wdata_o, 32'd0);
    chk("reset_raddr", 32'(vs_raddr_o), 32'd0);
    n_reset = 1'b1;
    q.push_back(mk(32'h3000, 4'b1100, 32'h0100_0000, 5'd4));
    q.push_back(mk(32'h3004, 4'b1111, 32'h0504_0302, 5'd4));
    q.push_back(mk(32'h3008, 4'b1111, 32'h0908_0706, 5'd4));
    q.push_back(mk(32'h300C, 4'b1111, 32'h0D0C_0B0A, 5'd4));
    q.push_back(mk(32'h3010, 4'b0011, 32'h0000_0F0E, 5'd4));
    q.push_back(mk(32'h3010, 4'b1100, 32'h1110_0000, 5'd5));
    run(5'd18, 2'd0, 1'b0, 32'h3002, 32'd0, 5'd4, 0, 0, 1'b0, 6);
    run(5'd0, 2'd0, 1'b0, 32'h4000, 32'd0, 5'd1, 0, 0, 1'b0, 0);
    run(5'd5, 2'd3, 1'b0, 32'h4000, 32'd0, 5'd1, 0, 0, 1'b0, 0);
    gw = 0; rw = 50;
    model(5'd8, 2'd0, 1'b0, 32'h0040, 32'd0, 5'd1);
    @(negedge clk);
    vl_i = 5'd8; vsew_i = 2'd0; vst_strided_i = 1'b0; op0_data_i = 32'h40; op1_data_i = 0; vr_addr_i = 5'd1;
    vst_en_i = 1'b1;
    g0 = grants;
    @(negedge clk);
    vst_en_i = 1'b0;
    for (int i = 0; i < 100 && grants == g0; i++) @(negedge clk);
    chk("abort_granted", 32'(grants - g0), 32'd1);
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("abort_req", 32'(bus.data_req_o), 32'd0);
    chk("abort_ready", 32'(vst_ready_o), 32'd1);
    chk("abort_no_done", 32'(vst_done_o), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done_hold", 32'(vst_done_o), 32'd0);
    end
    #1 n_reset = 1'b1;
    q.delete();
    for (int i = 0; i < 9; i++)
      run(tbl[i].vl, tbl[i].sew, tbl[i].str, tbl[i].base, tbl[i].stride, tbl[i].vr, tbl[i].gw, tbl[i].rw, 1'b1, tbl[i].n);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
